clb_config_loader: RTL and testbench

CLB_CONFIG_LOADER -- requirements
Module: clb_config_loader

---
 rtl/clb_config_loader_pkg.sv | 27 ++
 rtl/clb_config_loader_if.sv | 24 ++
 rtl/clb_config_loader.sv | 127 ++++++++++++
 tb/tb_clb_config_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clb_config_loader_pkg.sv
// Shared definitions for the CLB switch-box configuration loader: the loader
// state encoding and the helpers that size the configuration vector.
package clb_config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Switch-box configuration width: six switches per single-length track,
  // six per pair of double-length tracks.
  function automatic int calc_cw(input int ws, input int wd);
    return ws * 6 + (wd / 2) * 6;
  endfunction

  // Number of din words needed to cover cw bits.
  function automatic int calc_nw(input int cw, input int dw);
    return (cw + dw - 1) / dw;
  endfunction

  // Word counter width; never below one bit.
  function automatic int calc_cntw(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/clb_config_loader_if.sv
// Load handshake and configuration outputs of the CLB config loader.
interface clb_config_loader_if #(
  parameter int DW = 8,
  parameter int CW = 60
);
  logic          start;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] din;
  logic [CW-1:0] c;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, din_valid, din,
    input  din_ready, c, busy, done, err
  );

  modport slave (
    input  start, din_valid, din,
    output din_ready, c, busy, done, err
  );
endinterface

// File: rtl/clb_config_loader.sv
// Shifts a switch-box configuration in DW-bit words into a shadow register,
// then commits it to the active configuration in a single edge so the switch
// box never sees a partial configuration.
module clb_config_loader
  import clb_config_loader_pkg::*;
#(
  parameter int WS = 7,
  parameter int WD = 6,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  clb_config_loader_if.slave   bus
);

  localparam int CW   = calc_cw(WS, WD);
  localparam int NW   = calc_nw(CW, DW);
  localparam int CNTW = calc_cntw(NW);
  localparam int XW   = NW * DW;

  state_t          r_state;
  state_t          w_next;
  logic [CNTW-1:0] r_cnt;
  logic [CW-1:0]   r_shadow;
  logic [CW-1:0]   r_c;
  logic            r_done;
  logic            r_err;

  logic            w_last;
  logic            w_beat;
  logic            w_restart;
  logic            w_clear;
  logic            w_commit;
  logic [XW-1:0]   w_wide;
  logic [CW-1:0]   w_shadow_next;

  assign w_last = (r_cnt == CNTW'(NW - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-cycle control decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    w_beat    = 1'b0;
    w_restart = 1'b0;
    w_clear   = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next  = LOAD;
          w_clear = 1'b1;
        end
      end
      LOAD: begin
        // A restart wins over a beat arriving in the same cycle.
        if (bus.start) begin
          w_restart = 1'b1;
        end else if (bus.din_valid) begin
          w_beat = 1'b1;
          if (w_last) w_next = COMMIT;
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Word counter: restarts on every new or restarted load, wraps after the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cnt <= '0;
    else if (w_clear || w_restart) r_cnt <= '0;
    else if (w_beat)               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

  // Sticky restart flag, cleared only by a fresh start from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_clear)   r_err <= 1'b0;
    else if (w_restart) r_err <= 1'b1;
  end

  // Place the incoming word into a word-aligned view of the shadow; bits of
  // the last word above CW fall off when narrowed back.
  always_comb begin
    w_wide                          = XW'(r_shadow);
    w_wide[int'(r_cnt) * DW +: DW]  = bus.din;
    w_shadow_next                   = w_wide[CW-1:0];
  end

  // Shadow register, written one word per beat.
  // NOTE: this wide storage register is reset anyway, because a reset must
  // leave every switch open rather than expose stale configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_shadow <= '0;
    else if (w_beat) r_shadow <= w_shadow_next;
  end

  // Active configuration and done pulse, both updated on the edge leaving COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) r_c <= r_shadow;
    end
  end

  assign bus.din_ready = (r_state == LOAD);
  assign bus.busy      = (r_state != IDLE);
  assign bus.c         = r_c;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_clb_config_loader.sv
// Self-checking bench for clb_config_loader: directed scenarios plus
// randomized loads, compared against a transaction-level model of the
// active configuration and error flag.
module tb_clb_config_loader;

  localparam int WS = 7;
  localparam int WD = 6;
  localparam int DW = 8;
  localparam int CW = 60;
  localparam int NW = 8;

  typedef logic [DW-1:0] words_t [NW];

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clb_config_loader_if #(.DW(DW), .CW(CW)) bus ();

  clb_config_loader #(.WS(WS), .WD(WD), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the configuration the switch box should see and
  // the expected sticky error flag.
  logic [CW-1:0] m_c;
  logic          m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Concatenate words, word 0 in the low bits, keep the low CW bits.
  function automatic logic [CW-1:0] pack(input words_t w);
    logic [NW*DW-1:0] full;
    for (int j = 0; j < NW; j++) full[j*DW +: DW] = w[j];
    return full[CW-1:0];
  endfunction

  task automatic check_outputs(input string tag, input logic busy, input logic ready, input logic done);
    check({tag, ".c"},     64'(bus.c),         64'(m_c));
    check({tag, ".busy"},  64'(bus.busy),      64'(busy));
    check({tag, ".ready"}, 64'(bus.din_ready), 64'(ready));
    check({tag, ".done"},  64'(bus.done),      64'(done));
    check({tag, ".err"},   64'(bus.err),       64'(m_err));
  endtask

  // One beat, preceded by gap idle cycles during which c must hold.
  task automatic send_beat(input logic [DW-1:0] data, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.din_valid = 1'b0;
      bus.din       = DW'($urandom);
      tick();
      check_outputs("gap", 1'b1, 1'b1, 1'b0);
    end
    bus.din_valid = 1'b1;
    bus.din       = data;
    tick();
    bus.din_valid = 1'b0;
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any edge.
  task automatic mid_cycle_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    m_c   = '0;
    m_err = 1'b0;
    check_outputs(tag, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
  endtask

  // Full load transaction.
  //   junk >= 0  : send junk beats, then restart with a colliding beat
  //   reset_at>=0: reset after that many real beats, abandoning the load
  task automatic do_load(input words_t w, input int min_gap, input int max_gap,
                         input int junk, input int reset_at, input bit start_in_commit);
    logic [CW-1:0] new_c;
    new_c = pack(w);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_err     = 1'b0;
    check_outputs("start", 1'b1, 1'b1, 1'b0);

    if (junk >= 0) begin
      for (int k = 0; k < junk; k++) send_beat(DW'($urandom), 0);
      bus.start     = 1'b1;
      bus.din_valid = 1'b1;
      bus.din       = DW'($urandom);
      tick();
      bus.start     = 1'b0;
      bus.din_valid = 1'b0;
      m_err         = 1'b1;
      check_outputs("restart", 1'b1, 1'b1, 1'b0);
    end

    for (int k = 0; k < NW; k++) begin
      if (reset_at == k) begin
        mid_cycle_reset("load_rst");
        bus.din_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
          bus.din = DW'($urandom);
          tick();
          check_outputs("idle_valid", 1'b0, 1'b0, 1'b0);
        end
        bus.din_valid = 1'b0;
        return;
      end
      send_beat(w[k], (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0);
      if (k < NW - 1) check_outputs("beat", 1'b1, 1'b1, 1'b0);
    end

    // First edge after the last beat: COMMIT, c still old.
    check_outputs("commit", 1'b1, 1'b0, 1'b0);
    bus.start = start_in_commit;
    tick();
    bus.start = 1'b0;
    m_c = new_c;
    check_outputs("done", 1'b0, 1'b0, 1'b1);
    tick();
    check_outputs("after", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    words_t w;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    m_c           = '0;
    m_err         = 1'b0;
    #12;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    #5 rst = 1'b0;
    tick();
    check_outputs("post_reset", 1'b0, 1'b0, 1'b0);

    // Basic back-to-back load of 0x01..0x08.
    for (int j = 0; j < NW; j++) w[j] = DW'(j + 1);
    do_load(w, 0, 0, -1, -1, 1'b0);
    check("basic.const", 64'(bus.c), 64'h0807060504030201 & 64'hFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset while idle with a live configuration.
    tick();
    mid_cycle_reset("async_rst");
    tick();
    check_outputs("async_rst_hold", 1'b0, 1'b0, 1'b0);

    // Backpressure over a prior all-ones configuration.
    for (int j = 0; j < NW; j++) w[j] = 8'hFF;
    do_load(w, 0, 0, -1, -1, 1'b0);
    check("ones.const", 64'(bus.c), 64'h0FFF_FFFF_FFFF_FFFF);
    for (int j = 0; j < NW; j++) w[j] = DW'(j + 1);
    do_load(w, 1, 3, -1, -1, 1'b0);
    check("bp.const", 64'(bus.c), 64'h0807060504030201);

    // Restart after three beats, then 0xAA words; start in COMMIT ignored.
    for (int j = 0; j < NW; j++) w[j] = 8'hAA;
    do_load(w, 0, 0, 3, -1, 1'b1);
    check("restart.const", 64'(bus.c), 64'h0AAA_AAAA_AAAA_AAAA);
    check("restart.err", 64'(bus.err), 64'd1);

    // A later start from IDLE clears err (checked in the start phase).
    for (int j = 0; j < NW; j++) w[j] = DW'($urandom);
    do_load(w, 0, 0, -1, -1, 1'b0);

    // Reset after five beats: no done, c reads zero.
    for (int j = 0; j < NW; j++) w[j] = DW'($urandom);
    do_load(w, 0, 0, -1, 5, 1'b0);

    // Randomized loads.
    for (int it = 0; it < 40; it++) begin
      int r;
      for (int j = 0; j < NW; j++) w[j] = DW'($urandom);
      r = int'($urandom_range(9, 0));
      do_load(w, 0, int'($urandom_range(2, 0)),
              (r == 0) ? int'($urandom_range(NW - 1, 0)) : -1,
              (r == 1) ? int'($urandom_range(NW - 1, 0)) : -1,
              1'($urandom_range(1, 0)));
      repeat (int'($urandom_range(2, 0))) begin
        tick();
        check_outputs("idle", 1'b0, 1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
